// File: rtl/trg_frame_tx_if.sv
// Trigger-link GTX transmit bus.
//   TX_DATA    : 32-bit word for GTX TXDATA
//   TX_ISK     : 4-bit GTX TXCHARISK (one bit per byte, 1 = K-char)
//   FRAME_STRT : pulse coincident with word 0 of every frame
//   LTNCY_TRIG : pulse coincident with the last word of a marker frame
// master = frame builder (drives), slave = GTX wrapper / monitor (observes).
interface trg_frame_tx_if;
  logic [31:0] TX_DATA;
  logic [3:0]  TX_ISK;
  logic        FRAME_STRT;
  logic        LTNCY_TRIG;

  modport master (output TX_DATA, TX_ISK, FRAME_STRT, LTNCY_TRIG);
  modport slave  (input  TX_DATA, TX_ISK, FRAME_STRT, LTNCY_TRIG);
endinterface

// File: rtl/trg_frame_tx.sv
// Trigger-link frame builder for a buffer-bypass GTX transmitter (TXUSRCLK2).
// Packs NCH comparator bytes (or a PRBS-31 test pattern) plus a 16-bit K-char
// separator into WPF=(NCH+2)/4 32-bit words per frame, back to back. Every
// 2^MARK_LOG2-th frame is a latency marker (K28.7 separator). K28.5 idle commas
// are sent while the link is held in reset.
// Ports:
//   TRG_CLK80    : TXUSRCLK2 clock, rising edge
//   TRG_RST_N    : asynchronous active-low reset
//   TX_RST       : synchronous link reset, idle commas while high
//   ENA_TEST_PAT : 1 = PRBS payload, 0 = COMP_DATA payload (sampled at frame start)
//   INJ_ERR      : rising edge corrupts bit 0 of the next PRBS frame
//   COMP_DATA    : comparator bytes, byte 0 in [7:0]
//   FRAME_CNT    : frames sent (only with TRG_FRAME_CNT_EN defined)
//   gtx          : TX_DATA / TX_ISK / FRAME_STRT / LTNCY_TRIG (master modport)
// Optional feature macro: TRG_FRAME_CNT_EN (adds the FRAME_CNT port and counter).
module trg_frame_tx #(
  parameter int unsigned NCH       = 6,
  parameter int unsigned MARK_LOG2 = 8,
  parameter              PRBS_SEED = 48'hFFFFFF000000,
  parameter int unsigned PRBS_HOLD = 8
) (
  input  logic              TRG_CLK80,
  input  logic              TRG_RST_N,
  input  logic              TX_RST,
  input  logic              ENA_TEST_PAT,
  input  logic              INJ_ERR,
  input  logic [8*NCH-1:0]  COMP_DATA,
`ifdef TRG_FRAME_CNT_EN
  output logic [31:0]       FRAME_CNT,
`endif
  trg_frame_tx_if.master    gtx
);

  localparam int unsigned DW  = 8 * NCH;
  localparam int unsigned WPF = (NCH + 2) / 4;
  // PRBS-31 taps need at least 31 bits of history
  localparam int unsigned RW  = (DW < 31) ? 31 : DW;
  localparam int unsigned WCW = (WPF > 1) ? $clog2(WPF) : 1;

  localparam logic [RW-1:0]  SEED      = RW'(PRBS_SEED);
  localparam logic [WCW-1:0] WC_LAST   = WCW'(WPF - 1);
  localparam logic [31:0]    IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]     IDLE_ISK  = 4'b0101;
  localparam logic [15:0]    SEP_K285  = 16'h50BC;
  localparam logic [15:0]    SEP_K287  = 16'h50FC;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [WCW-1:0]        r_wc, w_wc_nxt;
  logic [MARK_LOG2-1:0]  r_mark_cnt, w_mark_cnt_nxt;
  logic [7:0]            r_hold_cnt, w_hold_cnt_nxt;
  logic [RW-1:0]         r_prbs, w_prbs_nxt, w_prbs_adv;
  logic [DW-1:0]         r_pay, w_pay_nxt, w_src;
  logic                  r_mark_frm, w_mark_nxt;
  logic                  r_inj_d, r_inj_pend, w_pend_nxt, w_inj_rise;
  logic [31:0]           r_tx_data, w_tx_data;
  logic [3:0]            r_tx_isk, w_tx_isk;
  logic                  r_frame_strt, w_strt;
  logic                  r_ltncy_trig, w_trig;
  logic                  w_active, w_fstart, w_fend;
  logic [32*WPF-1:0]     w_pad, w_shift;

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_active   = (r_state != S_IDLE);
    w_fstart   = w_active && (r_wc == '0);
    w_fend     = w_active && (r_wc == WC_LAST);
    w_inj_rise = INJ_ERR && !r_inj_d;

    // DW serial steps of x^31+x^28+1; MSB is the oldest (first transmitted) bit
    w_prbs_adv = r_prbs;
    for (int unsigned i = 0; i < DW; i++)
      w_prbs_adv = {w_prbs_adv[RW-2:0], w_prbs_adv[30] ^ w_prbs_adv[27]};

    // RUN transmits the freshly advanced pattern; HOLD keeps sending the seed
    w_src = (r_state == S_RUN) ? w_prbs_adv[DW-1:0] : r_prbs[DW-1:0];

    w_state_nxt    = r_state;
    w_wc_nxt       = r_wc;
    w_mark_cnt_nxt = r_mark_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_prbs_nxt     = r_prbs;
    w_pay_nxt      = r_pay;
    w_mark_nxt     = r_mark_frm;
    w_pend_nxt     = (r_inj_pend && !(w_fstart && ENA_TEST_PAT)) || w_inj_rise;

    case (r_state)
      S_IDLE:  w_state_nxt = (PRBS_HOLD == 0) ? S_RUN : S_HOLD;
      S_HOLD:  if (w_fend && ((r_hold_cnt + 8'd1) == 8'(PRBS_HOLD)))
                 w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_active) begin
      w_wc_nxt = w_fend ? '0 : r_wc + 1'b1;
      if (w_fstart) begin
        // error injection flips only the transmitted copy, never the LFSR
        w_pay_nxt      = ENA_TEST_PAT ? (w_src ^ DW'(r_inj_pend)) : COMP_DATA;
        w_mark_nxt     = (r_mark_cnt == '0);
        w_mark_cnt_nxt = r_mark_cnt + 1'b1;
        if (r_state == S_RUN) w_prbs_nxt = w_prbs_adv;
      end
      if (w_fend && (r_state == S_HOLD)) w_hold_cnt_nxt = r_hold_cnt + 8'd1;
    end

    if (TX_RST) begin
      w_state_nxt    = S_IDLE;
      w_wc_nxt       = '0;
      w_mark_cnt_nxt = '0;
      w_hold_cnt_nxt = '0;
      w_prbs_nxt     = SEED;
      w_pend_nxt     = 1'b0;
    end

    // Payload followed by separator is exactly WPF words; word k sits at the top after k shifts
    w_pad     = {w_pay_nxt, w_mark_nxt ? SEP_K287 : SEP_K285};
    w_shift   = w_pad << {r_wc, 5'd0};
    w_tx_data = IDLE_WORD;
    w_tx_isk  = IDLE_ISK;
    w_strt    = 1'b0;
    w_trig    = 1'b0;
    if (w_active && !TX_RST) begin
      w_tx_data = w_shift[32*WPF-1 -: 32];
      w_tx_isk  = (r_wc == WC_LAST) ? 4'b0001 : 4'b0000;
      w_strt    = w_fstart;
      w_trig    = w_fend && w_mark_nxt;
    end
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      r_wc         <= '0;
      r_mark_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_prbs       <= SEED;
      r_pay        <= '0;
      r_mark_frm   <= 1'b0;
      r_inj_d      <= 1'b0;
      r_inj_pend   <= 1'b0;
      r_tx_data    <= IDLE_WORD;
      r_tx_isk     <= IDLE_ISK;
      r_frame_strt <= 1'b0;
      r_ltncy_trig <= 1'b0;
    end else begin
      r_wc         <= w_wc_nxt;
      r_mark_cnt   <= w_mark_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_prbs       <= w_prbs_nxt;
      r_pay        <= w_pay_nxt;
      r_mark_frm   <= w_mark_nxt;
      r_inj_d      <= INJ_ERR;
      r_inj_pend   <= w_pend_nxt;
      r_tx_data    <= w_tx_data;
      r_tx_isk     <= w_tx_isk;
      r_frame_strt <= w_strt;
      r_ltncy_trig <= w_trig;
    end
  end

`ifdef TRG_FRAME_CNT_EN
  logic [31:0] r_frame_cnt;

  // Survives TX_RST; only the hard reset clears it
  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) r_frame_cnt <= '0;
    else            r_frame_cnt <= r_frame_cnt + {31'd0, w_strt};
  end

  assign FRAME_CNT = r_frame_cnt;
`endif

  assign gtx.TX_DATA    = r_tx_data;
  assign gtx.TX_ISK     = r_tx_isk;
  assign gtx.FRAME_STRT = r_frame_strt;
  assign gtx.LTNCY_TRIG = r_ltncy_trig;

endmodule

// File: tb/tb_trg_frame_tx.sv
// Directed bench for trg_frame_tx: two instances, NCH=6 (2 words/frame, 256-frame
// marker period, 8 held PRBS frames) and NCH=14 (4 words/frame, 4-frame marker
// period, no PRBS hold). Expected words are hand-derived from the frame layout;
// the PRBS reference is a bit-serial x^31+x^28+1 generator.
module tb_trg_frame_tx;
  logic         clk;
  logic         rst_n;
  logic         tx_rst1, ena1, inj1;
  logic [47:0]  comp1;
  logic         tx_rst2, ena2, inj2;
  logic [111:0] comp2;
  int unsigned  n_chk, n_fail;

  trg_frame_tx_if if1 ();
  trg_frame_tx_if if2 ();
`ifdef TRG_FRAME_CNT_EN
  logic [31:0] fcnt1, fcnt2;
`endif

  trg_frame_tx #(.NCH(6), .MARK_LOG2(8), .PRBS_SEED(48'hFFFFFF000000), .PRBS_HOLD(8)) u_dut1 (
    .TRG_CLK80(clk), .TRG_RST_N(rst_n), .TX_RST(tx_rst1), .ENA_TEST_PAT(ena1),
    .INJ_ERR(inj1), .COMP_DATA(comp1),
`ifdef TRG_FRAME_CNT_EN
    .FRAME_CNT(fcnt1),
`endif
    .gtx(if1));

  trg_frame_tx #(.NCH(14), .MARK_LOG2(2), .PRBS_SEED(48'hFFFFFF000000), .PRBS_HOLD(0)) u_dut2 (
    .TRG_CLK80(clk), .TRG_RST_N(rst_n), .TX_RST(tx_rst2), .ENA_TEST_PAT(ena2),
    .INJ_ERR(inj2), .COMP_DATA(comp2),
`ifdef TRG_FRAME_CNT_EN
    .FRAME_CNT(fcnt2),
`endif
    .gtx(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_data(input int dut);
    return (dut == 1) ? if1.TX_DATA : if2.TX_DATA;
  endfunction
  function automatic logic [3:0] obs_isk(input int dut);
    return (dut == 1) ? if1.TX_ISK : if2.TX_ISK;
  endfunction
  function automatic logic obs_strt(input int dut);
    return (dut == 1) ? if1.FRAME_STRT : if2.FRAME_STRT;
  endfunction
  function automatic logic obs_trig(input int dut);
    return (dut == 1) ? if1.LTNCY_TRIG : if2.LTNCY_TRIG;
  endfunction

  function automatic logic [111:0] prbs_adv(input logic [111:0] r, input int nbits);
    logic [111:0] v;
    v = r;
    for (int i = 0; i < nbits; i++) v = {v[110:0], v[30] ^ v[27]};
    return v;
  endfunction

  task automatic idle_chk(input int dut, input string tag);
    check_val({tag, "_data"}, obs_data(dut), 32'h50BC50BC);
    check_val({tag, "_isk"}, 32'(obs_isk(dut)), 32'h5);
    check_val({tag, "_pulses"}, 32'({obs_strt(dut), obs_trig(dut)}), 32'd0);
  endtask

  // bounded wait until word 0 of a frame is on the bus
  task automatic wait_strt(input int dut, input string tag);
    for (int i = 0; i < 6 && !obs_strt(dut); i++) tick();
    check_val({tag, "_strt_seen"}, 32'(obs_strt(dut)), 32'd1);
  endtask

  // called with word 0 on the bus; leaves the bench at word 0 of the next frame
  task automatic frame_chk(input int dut, input string tag, input logic [111:0] p, input logic mark);
    logic [127:0] pad, sh;
    logic [15:0]  sep;
    int           wpf;
    sep = mark ? 16'h50FC : 16'h50BC;
    if (dut == 1) begin
      wpf = 2;
      pad = {64'd0, p[47:0], sep};
    end else begin
      wpf = 4;
      pad = {p, sep};
    end
    for (int k = 0; k < wpf; k++) begin
      sh = pad >> (32 * (wpf - 1 - k));
      check_val($sformatf("%s_w%0d_data", tag, k), obs_data(dut), sh[31:0]);
      check_val($sformatf("%s_w%0d_isk", tag, k), 32'(obs_isk(dut)), (k == wpf - 1) ? 32'd1 : 32'd0);
      check_val($sformatf("%s_w%0d_strt", tag, k), 32'(obs_strt(dut)), 32'(k == 0));
      check_val($sformatf("%s_w%0d_trig", tag, k), 32'(obs_trig(dut)), 32'((k == wpf - 1) && mark));
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [111:0] m;
    int t1, t2, nstrt, nbad;
    logic prev;
`ifdef TRG_FRAME_CNT_EN
    logic [31:0] c0;
`endif
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    tx_rst1 = 1'b1; ena1 = 1'b0; inj1 = 1'b0; comp1 = 48'h060504030201;
    tx_rst2 = 1'b1; ena2 = 1'b0; inj2 = 1'b0; comp2 = 112'h0E0D0C0B0A0908070605040302_01;
    tick(3);

    idle_chk(1, "reset1");
    idle_chk(2, "reset2");
`ifdef TRG_FRAME_CNT_EN
    check_val("reset_fcnt", fcnt1, 32'd0);
`endif

    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      idle_chk(1, $sformatf("txrst%0d", i));
    end

    // frame layout, payload stability across the frame
    tx_rst1 = 1'b0;
    wait_strt(1, "lay1");
    comp1 = 48'hA1A2A3A4A5A6;
    frame_chk(1, "lay1_f0", 112'h060504030201, 1'b1);
    frame_chk(1, "lay1_f1", 112'hA1A2A3A4A5A6, 1'b0);

    // marker period: frame 256 is the next marker, its last word is at i=509
    t1 = -1; t2 = -1; nstrt = 0; nbad = 0; prev = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (if1.FRAME_STRT == prev) nbad++;
      prev = if1.FRAME_STRT;
      if (if1.LTNCY_TRIG) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      if (t1 >= 0 && t2 < 0 && if1.FRAME_STRT) nstrt++;
      tick();
    end
    check_val("mark_first", 32'(t1), 32'd509);
    check_val("mark_period", 32'(t2 - t1), 32'd512);
    check_val("mark_frames", 32'(nstrt), 32'd256);
    check_val("strt_alternate", 32'(nbad), 32'd0);

    // TX_RST on word 0 aborts the frame at once
    wait_strt(1, "abort");
    tx_rst1 = 1'b1;
    tick();
    idle_chk(1, "abort_next");
    tick(2);
    idle_chk(1, "abort_held");

    // PRBS: 8 frames of seed, then advancing 48 bits per frame
    ena1 = 1'b1;
    tx_rst1 = 1'b0;
    wait_strt(1, "prbs1");
    m = 112'hFFFFFF000000;
    for (int f = 0; f < 10; f++) begin
      if (f >= 8) m = prbs_adv(m, 48);
      frame_chk(1, $sformatf("prbs1_f%0d", f), m, f == 0);
    end

    // one INJ_ERR edge mid-frame corrupts only the following frame
    inj1 = 1'b1;
    m = prbs_adv(m, 48);
    frame_chk(1, "inj1_pre", m, 1'b0);
    inj1 = 1'b0;
    m = prbs_adv(m, 48);
    frame_chk(1, "inj1_hit", m ^ 112'd1, 1'b0);
    m = prbs_adv(m, 48);
    frame_chk(1, "inj1_post", m, 1'b0);

`ifdef TRG_FRAME_CNT_EN
    c0 = fcnt1;
    tick(2);
    check_val("fcnt_step", fcnt1, c0 + 32'd1);
`endif

    // NCH=14: four words per frame, marker every 4 frames
    tx_rst2 = 1'b0;
    wait_strt(2, "lay2");
    for (int f = 0; f < 5; f++)
      frame_chk(2, $sformatf("lay2_f%0d", f), comp2, (f % 4) == 0);

    tx_rst2 = 1'b1;
    tick();
    idle_chk(2, "rst2");
    ena2 = 1'b1;
    tx_rst2 = 1'b0;
    wait_strt(2, "prbs2");
    m = prbs_adv(112'hFFFFFF000000, 112);
    frame_chk(2, "prbs2_f0", m, 1'b1);

    // two INJ_ERR edges inside one frame still give a single error
    fork
      begin
        inj2 = 1'b1; tick();
        inj2 = 1'b0; tick();
        inj2 = 1'b1; tick();
        inj2 = 1'b0;
      end
    join_none
    m = prbs_adv(m, 112);
    frame_chk(2, "inj2_dbl", m, 1'b0);
    m = prbs_adv(m, 112);
    frame_chk(2, "inj2_hit", m ^ 112'd1, 1'b0);
    m = prbs_adv(m, 112);
    frame_chk(2, "inj2_post", m, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
